q2_io: RTL and testbench

Memory-mapped I/O responder for the q2 CPU bus at address 0xFFF. Bus writes to 0xFFF are queued and replayed to an HD44780-compatible character LCD (8-bit mode) with controller-safe timing. Bus reads from 0xFFF return a FIFO-room flag and debounced, active-low keypad levels. The block sits beside external RAM on `dbus`/`abus`/`wrm`/`rdm`; q2 is the bus initiator.

---
 rtl/q2_io.sv | 204 ++++++++++++++++++++
 tb/tb_q2_io.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_io.sv
// Memory-mapped I/O responder at 0xFFF: queued writes replayed to an HD44780 LCD
// with safe timing, reads return FIFO-room flag plus debounced active-low keys.
module q2_io #(
  parameter int INIT_CYCLES  = 2560,
  parameter int E_CYCLES     = 1,
  parameter int CMD_CYCLES   = 3,
  parameter int CLEAR_CYCLES = 106,
  parameter int DEB_CYCLES   = 320,
  parameter int FIFO_LOG2    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  inout  wire  [11:0] dbus,
  input  logic        wrm,
  input  logic        rdm,
  input  logic [10:0] key_n,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [7:0]  lcd_data,
  output logic        ovf
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = $clog2(INIT_CYCLES + CLEAR_CYCLES + CMD_CYCLES + E_CYCLES + 1);
  localparam int DW    = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_IDLE, S_DECODE, S_SETUP, S_E_HIGH, S_WAIT
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_idx;
  logic               r_init;
  logic               r_wrm_q;
  logic [FIFO_LOG2:0] r_wptr;
  logic [FIFO_LOG2:0] r_rptr;
  logic [8:0]         r_mem [DEPTH];
  logic [8:0]         r_ent;
  logic [10:0]        r_sync1;
  logic [10:0]        r_sync2;
  logic [10:0]        r_prev;
  logic [10:0]        r_keys;
  logic [DW-1:0]      r_deb_cnt;

  logic               w_wr_stb;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_tick;
  logic [CW-1:0]      w_wait_last;
  logic [10:0]        w_keys_next;
  logic               w_unused_dbus;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_byte = 8'h38;
      3'd2:       init_byte = 8'h0C;
      3'd3:       init_byte = 8'h01;
      default:    init_byte = 8'h06;
    endcase
  endfunction

  assign w_wr_stb      = wrm && !r_wrm_q && (abus == 12'hFFF);
  assign w_empty       = (r_wptr == r_rptr);
  assign w_full        = (r_wptr[FIFO_LOG2] != r_rptr[FIFO_LOG2]) &&
                         (r_wptr[FIFO_LOG2-1:0] == r_rptr[FIFO_LOG2-1:0]);
  assign w_pop         = (r_state == S_IDLE) && !w_empty;
  // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
  assign w_push        = w_wr_stb && (!w_full || w_pop);
  assign w_unused_dbus = ^dbus[11:9];

  assign dbus   = (rdm && abus == 12'hFFF) ? {~w_full, r_keys} : 12'bz;
  assign lcd_rw = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrm_q <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      ovf     <= 1'b0;
    end else begin
      r_wrm_q <= wrm;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_wr_stb && !w_push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[FIFO_LOG2-1:0]] <= dbus[8:0];
    if (w_pop)  r_ent <= r_mem[r_rptr[FIFO_LOG2-1:0]];
  end

  assign w_wait_last = (!lcd_rs && lcd_data == 8'h01) ? CW'(CLEAR_CYCLES - 1)
                                                      : CW'(CMD_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_INIT_WAIT;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_init   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      case (r_state)
        S_INIT_WAIT: begin
          if (r_cnt == CW'(INIT_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_init   <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_data <= init_byte(3'd0);
            r_state  <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (!w_empty) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_state <= S_SETUP;
          if (!r_ent[8]) begin
            lcd_rs   <= 1'b1;
            lcd_data <= (r_ent[7:0] < 8'h20 || r_ent[7:0] > 8'h7E) ? 8'h3F : r_ent[7:0];
          end else if (r_ent[7]) begin
            lcd_rs   <= 1'b0;
            lcd_data <= {1'b1, r_ent[6:0]};
          end else if (r_ent[0]) begin
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h01;
          end else begin
            lcd_rs   <= 1'b0;
            lcd_data <= r_ent[7:0];
          end
        end
        S_SETUP: begin
          lcd_e   <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_E_HIGH;
        end
        S_E_HIGH: begin
          if (r_cnt == CW'(E_CYCLES - 1)) begin
            lcd_e   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == w_wait_last) begin
            r_cnt <= '0;
            if (r_init && r_idx != 3'd4) begin
              r_idx    <= r_idx + 3'd1;
              lcd_data <= init_byte(r_idx + 3'd1);
              r_state  <= S_SETUP;
            end else begin
              r_init  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_INIT_WAIT;
      endcase
    end
  end

  assign w_tick = (r_deb_cnt == DW'(DEB_CYCLES - 1));

  // A key bit only follows the sample when two consecutive tick samples agree.
  generate
    for (genvar gi = 0; gi < 11; gi++) begin : g_deb
      assign w_keys_next[gi] = (r_sync2[gi] == r_prev[gi]) ? r_sync2[gi] : r_keys[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_prev    <= '1;
      r_keys    <= '1;
      r_deb_cnt <= '0;
    end else begin
      r_sync1   <= key_n;
      r_sync2   <= r_sync1;
      r_deb_cnt <= w_tick ? '0 : r_deb_cnt + 1'b1;
      if (w_tick) begin
        r_prev <= r_sync2;
        r_keys <= w_keys_next;
      end
    end
  end

endmodule

// File: tb/tb_q2_io.sv
// Bench for q2_io: random and directed bus traffic checked against a queue model
// of the LCD byte stream, plus timing, key debounce and bus read checks.
module tb_q2_io;
  localparam int INIT_CYCLES  = 2560;
  localparam int E_CYCLES     = 1;
  localparam int CMD_CYCLES   = 3;
  localparam int CLEAR_CYCLES = 106;
  localparam int DEB_CYCLES   = 320;
  localparam int DEPTH        = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] abus = 12'h000;
  wire  [11:0] dbus;
  logic [11:0] dbus_drv = 12'h000;
  logic        dbus_oe = 1'b0;
  logic        wrm = 1'b0;
  logic        rdm = 1'b0;
  logic [10:0] key_n = 11'h7FF;
  logic        lcd_rs, lcd_rw, lcd_e, ovf;
  logic [7:0]  lcd_data;

  assign dbus = dbus_oe ? dbus_drv : 12'bz;

  q2_io #(
    .INIT_CYCLES(INIT_CYCLES), .E_CYCLES(E_CYCLES), .CMD_CYCLES(CMD_CYCLES),
    .CLEAR_CYCLES(CLEAR_CYCLES), .DEB_CYCLES(DEB_CYCLES), .FIFO_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .abus(abus), .dbus(dbus), .wrm(wrm), .rdm(rdm),
    .key_n(key_n), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  // LCD observer: one record per rising edge of lcd_e
  logic [8:0] rx_q[$];
  int         rx_cyc[$];
  int         e_w[$];
  logic       e_prev = 1'b0;
  int         e_cnt  = 0;

  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      rx_q.push_back({lcd_rs, lcd_data});
      rx_cyc.push_back(cyc);
      $display("lcd   cyc=%0d rs=%0b data=0x%02h", cyc, lcd_rs, lcd_data);
      e_cnt <= 1;
    end else if (lcd_e) begin
      e_cnt <= e_cnt + 1;
    end
    if (!lcd_e && e_prev) e_w.push_back(e_cnt);
    e_prev <= lcd_e;
  end

  // Reference: what the LCD must show for a bus entry, {rs, byte}
  function automatic logic [8:0] model_lcd(input logic [8:0] d);
    if (!d[8])
      return {1'b1, (d[7:0] >= 8'h20 && d[7:0] <= 8'h7E) ? d[7:0] : 8'h3F};
    else if (d[7])
      return {1'b0, 8'h80 + {1'b0, d[6:0]}};
    else if (d[0])
      return {1'b0, 8'h01};
    else
      return {1'b0, d[7:0]};
  endfunction

  logic [8:0] exp_q[$];
  int         rx_rd = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_init_seq();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [11:0] d, input int hold,
                        output int pc);
    pc       = cyc + 1;
    abus     = a;
    dbus_drv = d;
    dbus_oe  = 1'b1;
    wrm      = 1'b1;
    repeat (hold) step();
    wrm = 1'b0;
    step();
    dbus_oe = 1'b0;
    abus    = 12'h000;
    $display("write cyc=%0d addr=0x%03h data=0x%03h hold=%0d", pc, a, d, hold);
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [11:0] v);
    abus = a;
    rdm  = 1'b1;
    #1;
    v    = dbus;
    rdm  = 1'b0;
    abus = 12'h000;
    $display("read  cyc=%0d addr=0x%03h data=0x%03h", cyc, a, v);
  endtask

  task automatic wait_rx(input int n, input int limit);
    int k = 0;
    while (rx_q.size() < n && k < limit) begin
      step();
      k++;
    end
    if (rx_q.size() < n) chk("timeout_rx", rx_q.size(), n);
  endtask

  task automatic consume();
    logic [8:0] e;
    while (rx_rd < rx_q.size() && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lcd_byte", {23'd0, rx_q[rx_rd]}, {23'd0, e});
      rx_rd++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [11:0] v;
    logic [8:0]  d;
    int pc, r0, n0, nb;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_data", lcd_data, 0);
    chk("rst_lcd_rw", lcd_rw, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dbus_z", dbus === 12'hzzz, 1);
    bus_rd(12'hFFF, v);
    chk("rst_read", v, 12'hFFF);

    rst = 1'b0;
    r0  = cyc;
    push_init_seq();
    repeat (5) step();

    // Six writes during init into a 4-deep FIFO; the first strobe is held 3 clocks
    for (int i = 0; i < 6; i++) begin
      bus_wr(12'hFFF, 12'h030 + 12'(i), (i == 0) ? 3 : 1, pc);
      if (i < DEPTH) exp_q.push_back(model_lcd(9'h030 + 9'(i)));
    end
    step();
    chk("ovf_set", ovf, 1);
    bus_rd(12'hFFF, v);
    chk("read_full_idle_keys", v, 12'h7FF);

    key_n = 11'h7F7;
    repeat (3 * DEB_CYCLES) step();
    bus_rd(12'hFFF, v);
    chk("read_keys_full", v, 12'h7F7);

    key_n = 11'h7F6;
    repeat (5) step();
    key_n = 11'h7F7;
    repeat (3 * DEB_CYCLES) step();
    bus_rd(12'hFFF, v);
    chk("key_glitch_ignored", v, 12'h7F7);
    chk("no_e_during_init_wait", rx_q.size(), 0);

    wait_rx(9, 3000);
    if (rx_q.size() >= 2) begin
      chk("init_delay_ok", (rx_cyc[0] - r0) >= INIT_CYCLES, 1);
      chk("init_byte_cost", rx_cyc[1] - rx_cyc[0], 1 + E_CYCLES + CMD_CYCLES);
    end
    consume();
    repeat (20) step();
    bus_rd(12'hFFF, v);
    chk("read_keys_room", v, 12'hFF7);

    // Directed writes, one at a time
    n0 = rx_q.size();
    exp_q.push_back(model_lcd(9'h041));
    bus_wr(12'hFFF, 12'h041, 1, pc);
    wait_rx(n0 + 1, 50);
    if (rx_q.size() > n0) chk("capture_latency", rx_cyc[n0] - pc, 3);
    foreach (v[i]) ;
    begin
      logic [8:0] dir_tab [4];
      dir_tab = '{9'h0FF, 9'h185, 9'h101, 9'h10C};
      for (int i = 0; i < 4; i++) begin
        n0 = rx_q.size();
        exp_q.push_back(model_lcd(dir_tab[i]));
        bus_wr(12'hFFF, {3'b000, dir_tab[i]}, 1, pc);
        wait_rx(n0 + 1, 300);
      end
    end
    consume();

    // Wrong address: no drive on read, no effect on write
    repeat (150) step();
    abus = 12'hFFE;
    rdm  = 1'b1;
    #1;
    chk("read_ffe_z", dbus === 12'hzzz, 1);
    rdm  = 1'b0;
    abus = 12'h000;
    n0 = rx_q.size();
    bus_wr(12'hFFE, 12'h041, 1, pc);
    repeat (30) step();
    chk("write_ffe_ignored", rx_q.size(), n0);

    // Random bursts of up to DEPTH writes
    for (int b = 0; b < 12; b++) begin
      n0 = rx_q.size();
      nb = $urandom_range(1, DEPTH);
      for (int j = 0; j < nb; j++) begin
        d = 9'($urandom_range(0, 511));
        exp_q.push_back(model_lcd(d));
        bus_wr(12'hFFF, {3'b000, d}, $urandom_range(1, 3), pc);
      end
      wait_rx(n0 + nb, 1500);
      consume();
    end
    chk("ovf_sticky", ovf, 1);

    // Reset while a clear command is on the bus
    n0 = rx_q.size();
    exp_q.push_back(model_lcd(9'h101));
    bus_wr(12'hFFF, 12'h101, 1, pc);
    wait_rx(n0 + 1, 50);
    consume();
    rst = 1'b1;
    step();
    chk("rst_mid_lcd_e", lcd_e, 0);
    chk("rst_mid_lcd_data", lcd_data, 0);
    chk("rst_mid_ovf", ovf, 0);
    rst = 1'b0;
    r0  = cyc;
    push_init_seq();
    wait_rx(n0 + 6, 3000);
    if (rx_q.size() > n0 + 1) chk("reinit_delay_ok", (rx_cyc[n0 + 1] - r0) >= INIT_CYCLES, 1);
    consume();

    // Post-run properties over the recorded stream
    for (int i = 0; i + 1 < rx_q.size(); i++)
      if (rx_q[i] == 9'h001)
        chk("clear_wait", (rx_cyc[i + 1] - rx_cyc[i]) >= (1 + E_CYCLES + CLEAR_CYCLES), 1);
    foreach (e_w[i]) chk("e_width", e_w[i], E_CYCLES);
    chk("all_expected_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
